combat_controller: RTL and testbench

//   Sequences the fight: runs one attack state machine per player, checks hits against
//   the physics-engine sprite positions, keeps both health counters and drives the round FSM.

---
 rtl/combat_controller_pkg.sv | 59 +++++
 rtl/combat_controller_attack_fsm.sv | 53 +++++
 rtl/combat_controller.sv | 154 +++++++++++++++
 tb/tb_combat_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_controller_pkg.sv
// Shared encodings, tuning constants and helpers for combat_controller.
// Optional feature macro: BLOCK_GUARD_EN (blocking defenders take reduced damage).
package combat_controller_pkg;

   localparam int MAX_HEALTH    = 31;
   localparam int DAMAGE        = 4;
   localparam int REACH         = 12;
   localparam int Y_REACH       = 8;
   localparam int WINDUP_TICKS  = 3;
   localparam int RECOVER_TICKS = 10;
   localparam int KO_TICKS      = 120;

   localparam int HEALTH_W = 5;
   localparam int TIMER_W  = 4;
   localparam int KO_W     = 7;

   typedef enum logic [1:0] {
      ATK_IDLE    = 2'b00,
      ATK_WINDUP  = 2'b01,
      ATK_ACTIVE  = 2'b10,
      ATK_RECOVER = 2'b11
   } attack_state_t;

   typedef enum logic [1:0] {
      CHAR_IDLE   = 2'b00,
      CHAR_ATTACK = 2'b01,
      CHAR_HURT   = 2'b10,
      CHAR_KO     = 2'b11
   } char_state_t;

   typedef enum logic [1:0] {
      RND_FIGHT   = 2'b00,
      RND_KO      = 2'b01,
      RND_RESTART = 2'b10
   } round_state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   // Saturating subtract: health never wraps below zero, even if dmg exceeds it.
   function automatic logic [HEALTH_W-1:0] apply_damage(input logic [HEALTH_W-1:0] health,
                                                        input logic [7:0] dmg);
      logic [HEALTH_W-1:0] result;
      result = '0;
      if (8'(health) > dmg) result = health - dmg[HEALTH_W-1:0];
      return result;
   endfunction

   function automatic logic [7:0] abs8(input logic signed [7:0] v);
      logic [7:0] result;
      result = v[7] ? 8'(-v) : 8'(v);
      return result;
   endfunction

endpackage

// File: rtl/combat_controller_attack_fsm.sv
// Per-player attack sequencer: IDLE -> WINDUP -> ACTIVE (one tick) -> RECOVER -> IDLE.
module attack_fsm
   import combat_controller_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic attack,
   input  logic enable,
   output logic active_now,
   output logic busy
);

   attack_state_t state;
   logic [TIMER_W-1:0] timer;

   // Losing enable (round left FIGHT) cancels any attack immediately, tick or not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ATK_IDLE;
         timer <= '0;
      end else if (!enable) begin
         state <= ATK_IDLE;
         timer <= '0;
      end else if (tick) begin
         case (state)
            ATK_IDLE: begin
               if (attack) begin
                  state <= ATK_WINDUP;
                  timer <= TIMER_W'(WINDUP_TICKS);
               end
            end
            ATK_WINDUP: begin
               timer <= timer - TIMER_W'(1);
               if (timer == TIMER_W'(1)) state <= ATK_ACTIVE;
            end
            ATK_ACTIVE: begin
               state <= ATK_RECOVER;
               timer <= TIMER_W'(RECOVER_TICKS);
            end
            ATK_RECOVER: begin
               timer <= timer - TIMER_W'(1);
               if (timer == TIMER_W'(1)) state <= ATK_IDLE;
            end
            default: state <= ATK_IDLE;
         endcase
      end
   end

   assign active_now = enable && tick && (state == ATK_ACTIVE);
   assign busy       = (state != ATK_IDLE);

endmodule

// File: rtl/combat_controller.sv
// Fight sequencer: two attack FSMs, hit check, health counters and round FSM.
// Optional feature macro: BLOCK_GUARD_EN adds p1_block/p2_block damage reduction.
module combat_controller
   import combat_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       p1_attack,
   input  logic       p2_attack,
   input  logic [6:0] p1_x,
   input  logic [6:0] p1_y,
   input  logic [6:0] p2_x,
   input  logic [6:0] p2_y,
`ifdef BLOCK_GUARD_EN
   input  logic       p1_block,
   input  logic       p2_block,
`endif
   output logic [4:0] health_l,
   output logic [4:0] health_r,
   output logic [1:0] p1_state,
   output logic [1:0] p2_state,
   output logic [1:0] round_state,
   output logic [1:0] winner
);

   round_state_t      round_q;
   winner_t           winner_q;
   logic [KO_W-1:0]   ko_count;
   logic              fight;
   logic              p1_busy, p2_busy, p1_active, p2_active;
   logic              hurt_l, hurt_r;
   logic signed [7:0] dx, dy;
   logic              in_range;
   logic              hit_on_l, hit_on_r;
   logic              guard_l, guard_r;
   logic [7:0]        dmg_l, dmg_r;

   assign fight = (round_q == RND_FIGHT);

   attack_fsm u_p1_fsm (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .attack     (p1_attack),
      .enable     (fight),
      .active_now (p1_active),
      .busy       (p1_busy)
   );

   attack_fsm u_p2_fsm (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .attack     (p2_attack),
      .enable     (fight),
      .active_now (p2_active),
      .busy       (p2_busy)
   );

   // Reach is symmetric, so one range test serves both attack directions.
   assign dx       = $signed({1'b0, p1_x}) - $signed({1'b0, p2_x});
   assign dy       = $signed({1'b0, p1_y}) - $signed({1'b0, p2_y});
   assign in_range = (abs8(dx) <= 8'(REACH)) && (abs8(dy) <= 8'(Y_REACH));

   assign hit_on_r = p1_active && in_range && fight;
   assign hit_on_l = p2_active && in_range && fight;

`ifdef BLOCK_GUARD_EN
   assign guard_l = p1_block && !p1_busy;
   assign guard_r = p2_block && !p2_busy;
`else
   assign guard_l = 1'b0;
   assign guard_r = 1'b0;
`endif

   assign dmg_l = guard_l ? 8'(DAMAGE >> 2) : 8'(DAMAGE);
   assign dmg_r = guard_r ? 8'(DAMAGE >> 2) : 8'(DAMAGE);

   // Both hits are applied independently so a same-tick trade damages both players.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         health_l <= HEALTH_W'(MAX_HEALTH);
         health_r <= HEALTH_W'(MAX_HEALTH);
         hurt_l   <= 1'b0;
         hurt_r   <= 1'b0;
      end else if (round_q == RND_RESTART) begin
         health_l <= HEALTH_W'(MAX_HEALTH);
         health_r <= HEALTH_W'(MAX_HEALTH);
         hurt_l   <= 1'b0;
         hurt_r   <= 1'b0;
      end else begin
         if (tick) begin
            hurt_l <= 1'b0;
            hurt_r <= 1'b0;
         end
         if (hit_on_l) begin
            health_l <= apply_damage(health_l, dmg_l);
            hurt_l   <= !guard_l;
         end
         if (hit_on_r) begin
            health_r <= apply_damage(health_r, dmg_r);
            hurt_r   <= !guard_r;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_q  <= RND_FIGHT;
         winner_q <= WIN_NONE;
         ko_count <= '0;
      end else begin
         case (round_q)
            RND_FIGHT: begin
               if (health_l == '0 || health_r == '0) begin
                  round_q  <= RND_KO;
                  ko_count <= '0;
                  if (health_l == '0 && health_r == '0) winner_q <= WIN_DRAW;
                  else if (health_r == '0)               winner_q <= WIN_P1;
                  else                                   winner_q <= WIN_P2;
               end
            end
            RND_KO: begin
               if (tick) begin
                  if (ko_count == KO_W'(KO_TICKS - 1)) round_q <= RND_RESTART;
                  else                                 ko_count <= ko_count + KO_W'(1);
               end
            end
            default: begin
               round_q  <= RND_FIGHT;
               winner_q <= WIN_NONE;
               ko_count <= '0;
            end
         endcase
      end
   end

   // A KO'd player overrides everything; an attacking player never shows hurt.
   always_comb begin
      p1_state = CHAR_IDLE;
      p2_state = CHAR_IDLE;
      if (round_q == RND_KO && (winner_q == WIN_P2 || winner_q == WIN_DRAW)) p1_state = CHAR_KO;
      else if (p1_busy)                                                      p1_state = CHAR_ATTACK;
      else if (hurt_l)                                                       p1_state = CHAR_HURT;
      if (round_q == RND_KO && (winner_q == WIN_P1 || winner_q == WIN_DRAW)) p2_state = CHAR_KO;
      else if (p2_busy)                                                      p2_state = CHAR_ATTACK;
      else if (hurt_r)                                                       p2_state = CHAR_HURT;
   end

   assign round_state = round_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_combat_controller.sv
// Self-checking bench for combat_controller: geometry table, hand-written
// timing/KO/reset sequences, then randomized play against a timeline model.
module tb_combat_controller;

   logic       clk = 1'b0;
   logic       reset, tick, p1_attack, p2_attack;
   logic [6:0] p1_x, p1_y, p2_x, p2_y;
   logic [4:0] health_l, health_r;
   logic [1:0] p1_state, p2_state, round_state, winner;

   int errors = 0;
   int checks = 0;

   combat_controller dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .p1_attack   (p1_attack),
      .p2_attack   (p2_attack),
      .p1_x        (p1_x),
      .p1_y        (p1_y),
      .p2_x        (p2_x),
      .p2_y        (p2_y),
`ifdef BLOCK_GUARD_EN
      .p1_block    (1'b0),
      .p2_block    (1'b0),
`endif
      .health_l    (health_l),
      .health_r    (health_r),
      .p1_state    (p1_state),
      .p2_state    (p2_state),
      .round_state (round_state),
      .winner      (winner)
   );

   always #5 clk = ~clk;

   // Reference model: an attack is a timeline measured in ticks since it was accepted.
   int m_age [2];
   int m_hl, m_hr, m_round, m_winner, m_kot;
   bit m_hurt [2];

   function automatic void model_reset();
      m_age[0] = -1; m_age[1] = -1;
      m_hurt[0] = 0; m_hurt[1] = 0;
      m_hl = 31; m_hr = 31;
      m_round = 0; m_winner = 0; m_kot = 0;
   endfunction

   function automatic void model_update();
      bit fight, restart, near, hit_l, hit_r;
      bit req [2];
      int dx, dy;
      if (reset) begin
         model_reset();
         return;
      end
      fight   = (m_round == 0);
      restart = (m_round == 2);
      dx      = int'(p1_x) - int'(p2_x);
      dy      = int'(p1_y) - int'(p2_y);
      near    = (dx >= -12 && dx <= 12 && dy >= -8 && dy <= 8);
      hit_r   = fight && tick && m_age[0] == 3 && near;
      hit_l   = fight && tick && m_age[1] == 3 && near;
      req[0]  = p1_attack;
      req[1]  = p2_attack;
      case (m_round)
         0: if (m_hl == 0 || m_hr == 0) begin
               m_winner = (m_hl == 0 && m_hr == 0) ? 3 : (m_hr == 0) ? 1 : 2;
               m_round  = 1;
               m_kot    = 0;
            end
         1: if (tick) begin
               m_kot++;
               if (m_kot == 120) m_round = 2;
            end
         default: begin
            m_round  = 0;
            m_winner = 0;
         end
      endcase
      for (int i = 0; i < 2; i++) begin
         if (!fight) m_age[i] = -1;
         else if (tick) begin
            if (m_age[i] < 0) begin
               if (req[i]) m_age[i] = 0;
            end else begin
               m_age[i]++;
               if (m_age[i] == 14) m_age[i] = -1;
            end
         end
      end
      if (restart) begin
         m_hl = 31; m_hr = 31;
         m_hurt[0] = 0; m_hurt[1] = 0;
      end else begin
         if (tick) begin
            m_hurt[0] = 0; m_hurt[1] = 0;
         end
         if (hit_l) begin
            m_hl = (m_hl > 4) ? m_hl - 4 : 0;
            m_hurt[0] = 1;
         end
         if (hit_r) begin
            m_hr = (m_hr > 4) ? m_hr - 4 : 0;
            m_hurt[1] = 1;
         end
      end
   endfunction

   function automatic int model_pstate(int i);
      bit lost;
      lost = (m_round == 1) && (m_winner == 3 || (i == 0 ? m_winner == 2 : m_winner == 1));
      if (lost)          return 3;
      if (m_age[i] >= 0) return 1;
      if (m_hurt[i])     return 2;
      return 0;
   endfunction

   function automatic logic [31:0] model_vec();
      return 32'((m_hl << 13) | (m_hr << 8) | (model_pstate(0) << 6) |
                 (model_pstate(1) << 4) | (m_round << 2) | m_winner);
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({health_l, health_r, p1_state, p2_state, round_state, winner});
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle starting and ending at a falling edge.
   task automatic apply_stimulus(input logic t);
      tick = t;
      @(posedge clk);
      model_update();
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         apply_stimulus(1'b1);
         apply_stimulus(1'b0);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick = 1'b0; p1_attack = 1'b0; p2_attack = 1'b0;
      apply_stimulus(1'b0);
      apply_stimulus(1'b0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic trigger(input logic a1, input logic a2);
      p1_attack = a1; p2_attack = a2;
      apply_stimulus(1'b1);
      p1_attack = 1'b0; p2_attack = 1'b0;
      apply_stimulus(1'b0);
   endtask

   task automatic place(input int x1, input int y1, input int x2, input int y2);
      p1_x = 7'(x1); p1_y = 7'(y1); p2_x = 7'(x2); p2_y = 7'(y2);
   endtask

   typedef struct {
      int         x1, y1, x2, y2;
      logic [4:0] exp_hr;
   } geo_vec_t;

   geo_vec_t geo [10];

   initial begin
      geo[0] = '{40, 48, 50, 48, 5'd27};
      geo[1] = '{40, 48, 52, 48, 5'd27};
      geo[2] = '{40, 48, 53, 48, 5'd31};
      geo[3] = '{60, 48, 48, 48, 5'd27};
      geo[4] = '{40, 48, 60, 48, 5'd31};
      geo[5] = '{40, 40, 45, 48, 5'd27};
      geo[6] = '{40, 40, 45, 49, 5'd31};
      geo[7] = '{40, 57, 45, 48, 5'd31};
      geo[8] = '{0, 0, 127, 127, 5'd31};
      geo[9] = '{127, 0, 120, 8, 5'd27};

      place(40, 48, 50, 48);
      apply_reset();
      check_output("reset_state", dut_vec(), {14'd0, 5'd31, 5'd31, 8'd0});

      for (int i = 0; i < 10; i++) begin
         apply_reset();
         place(geo[i].x1, geo[i].y1, geo[i].x2, geo[i].y2);
         trigger(1'b1, 1'b0);
         run_ticks(14);
         check_output($sformatf("geo%0d_health_r", i), 32'(health_r), 32'(geo[i].exp_hr));
         check_output($sformatf("geo%0d_p1_idle", i), 32'(p1_state), 32'd0);
      end

      // Hit timing: damage lands on the 4th tick after the accepting tick.
      apply_reset();
      place(40, 48, 50, 48);
      trigger(1'b1, 1'b0);
      check_output("windup_p1_state", 32'(p1_state), 32'd1);
      run_ticks(3);
      check_output("pre_hit_health_r", 32'(health_r), 32'd31);
      run_ticks(1);
      check_output("hit_health_r", 32'(health_r), 32'd27);
      check_output("hit_p2_hurt", 32'(p2_state), 32'd2);
      run_ticks(1);
      check_output("hurt_clears", 32'(p2_state), 32'd0);
      run_ticks(8);
      check_output("recover_p1_state", 32'(p1_state), 32'd1);
      run_ticks(1);
      check_output("recover_done", 32'(p1_state), 32'd0);

      apply_reset();
      place(40, 48, 50, 48);
      trigger(1'b1, 1'b1);
      run_ticks(4);
      check_output("trade_health", 32'({health_l, health_r}), 32'({5'd27, 5'd27}));

      // KO: eight hits take 31 down to 0 without wrapping.
      apply_reset();
      place(40, 48, 50, 48);
      repeat (7) begin
         trigger(1'b1, 1'b0);
         run_ticks(14);
      end
      check_output("ko_pre_health_r", 32'(health_r), 32'd3);
      trigger(1'b1, 1'b0);
      run_ticks(4);
      check_output("ko_health_r", 32'(health_r), 32'd0);
      check_output("ko_round", 32'({round_state, winner}), 32'({2'b01, 2'b01}));
      check_output("ko_p2_state", 32'(p2_state), 32'd3);
      apply_stimulus(1'b0);
      check_output("ko_p1_forced_idle", 32'(p1_state), 32'd0);
      p1_attack = 1'b1;
      run_ticks(119);
      check_output("ko_hold_round", 32'(round_state), 32'd1);
      check_output("ko_ignores_attack", 32'({p1_state, health_l, health_r}), 32'({2'd0, 5'd31, 5'd0}));
      p1_attack = 1'b0;
      apply_stimulus(1'b1);
      check_output("restart_round", 32'(round_state), 32'd2);
      apply_stimulus(1'b0);
      check_output("new_round", dut_vec(), {14'd0, 5'd31, 5'd31, 8'd0});

      // Reset mid-WINDUP, with ticks and requests while held in reset.
      apply_reset();
      place(40, 48, 50, 48);
      trigger(1'b1, 1'b0);
      run_ticks(1);
      check_output("midwindup_p1_state", 32'(p1_state), 32'd1);
      reset = 1'b1;
      #1;
      check_output("async_reset_p1_state", 32'(p1_state), 32'd0);
      p1_attack = 1'b1;
      repeat (3) apply_stimulus(1'b1);
      check_output("tick_in_reset", 32'({p1_state, health_r}), 32'({2'd0, 5'd31}));
      reset = 1'b0;
      p1_attack = 1'b0;
      model_reset();
      run_ticks(15);
      check_output("no_damage_after_reset", dut_vec(), {14'd0, 5'd31, 5'd31, 8'd0});

      // Randomized play against the timeline model.
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         p1_attack = ($urandom_range(0, 2) == 0);
         p2_attack = ($urandom_range(0, 2) == 0);
         place($urandom_range(30, 60), $urandom_range(42, 54),
               $urandom_range(30, 60), $urandom_range(42, 54));
         apply_stimulus(1'($urandom_range(0, 1)));
         check_output("random", dut_vec(), model_vec());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
